// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bit-serial logic unit between two requesters
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             last;
  logic             lu_bit;
  logic             win1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    win1 = req1 & (~req0 | ~last);
  end

  // One-bit logic unit applied to the current LSBs of the latched operands.
  always_comb begin
    lu_bit = 1'b0;
    case (op_q)
      3'd0:    lu_bit = a_q[0] & b_q[0];
      3'd1:    lu_bit = a_q[0] | b_q[0];
      3'd2:    lu_bit = a_q[0] ^ b_q[0];
      3'd3:    lu_bit = ~(a_q[0] & b_q[0]);
      3'd4:    lu_bit = ~(a_q[0] | b_q[0]);
      3'd5:    lu_bit = ~(a_q[0] ^ b_q[0]);
      3'd6:    lu_bit = ~a_q[0];
      default: lu_bit = a_q[0];
    endcase
  end

  // Anything other than IDLE counts as a job in progress.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // FSM: grant in IDLE, shift operands LSB first in RUN, publish the result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      cnt       <= '0;
      id_q      <= 1'b0;
      last      <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_id <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            ack0  <= ~win1;
            ack1  <= win1;
            id_q  <= win1;
            last  <= win1;
            op_q  <= win1 ? op1 : op0;
            a_q   <= win1 ? a1 : a0;
            b_q   <= win1 ? b1 : b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_q  <= a_q >> 1;
          b_q  <= b_q >> 1;
          work <= {lu_bit, work[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // The final bit goes straight into the visible result alongside done.
            result    <= {lu_bit, work[WIDTH-1:1]};
            result_id <= id_q;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [2:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1, busy, done, result_id;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .result(result), .result_id(result_id)
  );

  always #5 clk = ~clk;

  // Reference model: a job timeline, whole-word logic ops, and a last-served pointer.
  int               m_remain;
  logic             m_last;
  logic             m_ack0, m_ack1, m_done, m_id, m_pend_id;
  logic [WIDTH-1:0] m_result, m_pend;

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    m_remain = 0; m_last = 1'b1; m_result = '0; m_id = 1'b0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    logic w;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_done = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (m_remain == 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? ~m_last : req1;
        m_ack0 = ~w; m_ack1 = w; m_last = w;
        m_pend = w ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
        m_pend_id = w;
        m_remain = WIDTH + 1;
      end
    end else begin
      m_remain--;
      if (m_remain == 1) begin
        m_done = 1'b1; m_result = m_pend; m_id = m_pend_id;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("ack0", ack0, m_ack0);
    chk("ack1", ack1, m_ack1);
    chk("done", done, m_done);
    chk("busy", busy, m_remain != 0);
    chk("result", result, m_result);
    chk("result_id", result_id, m_id);
    chk("ack_exclusive", ack0 & ack1, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   cyc;
  int   acks_seen;
  int   idle_cnt;
  int   ids[$];

  initial begin
    vecs[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{3'd3, 8'hC5, 8'h0F, 8'hFA};
    vecs[2] = '{3'd4, 8'hC5, 8'h0F, 8'h30};
    vecs[3] = '{3'd5, 8'hC5, 8'h0F, 8'h35};
    vecs[4] = '{3'd6, 8'hC5, 8'h0F, 8'h3A};
    vecs[5] = '{3'd7, 8'hC5, 8'h0F, 8'hC5};
    vecs[6] = '{3'd2, 8'hAA, 8'hFF, 8'h55};
    vecs[7] = '{3'd1, 8'hC5, 8'h0F, 8'hCF};

    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    do_reset();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_result_id", result_id, 0);

    // Single-requester jobs from the vector table.
    foreach (vecs[i]) begin
      req0 = 1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b;
      step();
      chk("tbl_ack0", ack0, 1);
      req0 = 0;
      wait_done(cyc);
      chk("tbl_latency", cyc, WIDTH);
      chk("tbl_result", result, vecs[i].exp);
      chk("tbl_result_id", result_id, 0);
      step();
    end

    // Tie from reset: requester 0 first, requester 1 ten cycles later.
    do_reset();
    req0 = 1; req1 = 1; op0 = 3'd0; a0 = 8'h0F; b0 = 8'hFF; op1 = 3'd2; a1 = 8'hAA; b1 = 8'hFF;
    step();
    chk("tie_first_ack0", ack0, 1);
    cyc = 0;
    do begin step(); cyc++; end while (!ack1 && cyc < 30);
    chk("tie_ack1_gap", cyc, WIDTH + 2);
    req0 = 0; req1 = 0;
    wait_done(cyc);
    chk("tie_result", result, 8'h55);
    chk("tie_result_id", result_id, 1);
    step();

    // Operand change after ack must not disturb the job.
    req0 = 1; op0 = 3'd7; a0 = 8'h01; b0 = 8'h00;
    step();
    req0 = 0;
    step(); step();
    a0 = 8'hFF;
    wait_done(cyc);
    chk("late_change_result", result, 8'h01);
    step();

    // Asynchronous reset during bit 4 of a job.
    req0 = 1; op0 = 3'd0; a0 = 8'hFF; b0 = 8'hFF;
    step();
    req0 = 0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_ack0", ack0, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_result_id", result_id, 0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    repeat (WIDTH + 3) step();
    req0 = 1; op0 = 3'd1; a0 = 8'h50; b0 = 8'h05;
    step();
    chk("post_rst_ack0", ack0, 1);
    req0 = 0;
    wait_done(cyc);
    chk("post_rst_result", result, 8'h55);
    step();

    // Continuous tie: six alternating jobs with a single idle cycle between them.
    do_reset();
    req0 = 1; req1 = 1;
    acks_seen = 0; idle_cnt = 0; cyc = 0;
    while (acks_seen < 6 && cyc < 100) begin
      step(); cyc++;
      if (ack0 || ack1) begin
        if (acks_seen > 0) chk("rr_idle_gap", idle_cnt, 1);
        ids.push_back(int'(ack1));
        acks_seen++;
        idle_cnt = 0;
      end else if (!busy) begin
        idle_cnt++;
      end
    end
    chk("rr_ack_count", acks_seen, 6);
    foreach (ids[k]) chk("rr_order", ids[k], k % 2);
    req0 = 0; req1 = 0;
    wait_done(cyc);
    step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
      a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
